mmio_display_responder: RTL and testbench

Memory-mapped peripheral that responds to data-memory-bus accesses issued by the CPU MEM stage and drives the 12-bit seven-segment bus `digi`.
- Holds a display data register and a control register.
- Time-multiplexes four digits using a prescaled scan counter.
- Returns register contents on reads.
- Sits beside data memory; the MEM stage muxes `rdata` in when `hit` is set.

---
 rtl/mmio_display_responder_pkg.sv | 19 +
 rtl/mmio_display_responder_seg_hex_decoder.sv | 12 +
 rtl/mmio_display_responder.sv | 123 ++++++++++++
 tb/tb_mmio_display_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_display_responder_pkg.sv
// Shared constants for the MMIO seven-segment display responder: register offsets,
// control bit positions, the blank output pattern and the hex-to-segment table.
package mmio_display_pkg;

  localparam logic [31:0] DATA_OFF   = 32'h0;
  localparam logic [31:0] CTRL_OFF   = 32'h4;
  localparam logic [31:0] STATUS_OFF = 32'h8;

  localparam int SCAN_EN_BIT = 0;

  localparam logic [11:0] DIGI_OFF = 12'hFFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp always off; entry 15 is listed first
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/mmio_display_responder_seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
// Only instantiated when MMIO_DISPLAY_SEG_DECODE_EN is defined.
module seg_hex_decoder
  import mmio_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/mmio_display_responder.sv
// Memory-mapped four-digit seven-segment display controller on the data-memory bus.
// Define MMIO_DISPLAY_SEG_DECODE_EN to decode hex nibbles instead of raw segment bytes.
module mmio_display_responder
  import mmio_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int          SCAN_DIV  = 100000,
  parameter int          DIV_W     = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [11:0] digi
);

  localparam logic [31:0]      DATA_ADDR   = BASE_ADDR + DATA_OFF;
  localparam logic [31:0]      CTRL_ADDR   = BASE_ADDR + CTRL_OFF;
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + STATUS_OFF;
  localparam logic [DIV_W-1:0] PRESC_LAST  = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      dataReg;
  logic             scanEn;
  logic [DIV_W-1:0] prescaler;
  logic [1:0]       idx;

  logic       hitData, hitCtrl, hitStatus;
  logic       startScan;
  logic [3:0] anode;
  logic [7:0] curSeg;
  logic       unusedBits;

  assign hitData   = (addr[31:2] == DATA_ADDR[31:2]);
  assign hitCtrl   = (addr[31:2] == CTRL_ADDR[31:2]);
  assign hitStatus = (addr[31:2] == STATUS_ADDR[31:2]);
  assign hit       = hitData | hitCtrl | hitStatus;

  // Only a 0->1 transition of SCAN_EN restarts the scan; rewriting 1 keeps the current slot
  assign startScan = mem_wr & hitCtrl & wdata[SCAN_EN_BIT] & ~scanEn;

  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (hitData)        rdata = dataReg;
      else if (hitCtrl)   rdata = {31'b0, scanEn};
      else if (hitStatus) rdata = {30'b0, idx};
    end
  end

  assign anode = ~(4'b0001 << idx);

`ifdef MMIO_DISPLAY_SEG_DECODE_EN
  logic [3:0] curNibble;
  logic [7:0] decodedSeg;
  logic       curBlank;

  always_comb begin
    curNibble = dataReg[3:0];
    curBlank  = dataReg[16];
    case (idx)
      2'd0: begin curNibble = dataReg[3:0];   curBlank = dataReg[16]; end
      2'd1: begin curNibble = dataReg[7:4];   curBlank = dataReg[17]; end
      2'd2: begin curNibble = dataReg[11:8];  curBlank = dataReg[18]; end
      2'd3: begin curNibble = dataReg[15:12]; curBlank = dataReg[19]; end
      default: ;
    endcase
  end

  seg_hex_decoder uDecoder (
    .nibble (curNibble),
    .seg    (decodedSeg)
  );

  assign curSeg     = curBlank ? 8'hFF : decodedSeg;
  assign unusedBits = ^{addr[1:0], dataReg[31:20]};
`else
  always_comb begin
    curSeg = dataReg[7:0];
    case (idx)
      2'd0: curSeg = dataReg[7:0];
      2'd1: curSeg = dataReg[15:8];
      2'd2: curSeg = dataReg[23:16];
      2'd3: curSeg = dataReg[31:24];
      default: ;
    endcase
  end

  assign unusedBits = ^addr[1:0];
`endif

  // Register file, scan sequencing and the registered digit output share one clocked block
  always_ff @(posedge clk) begin
    if (reset) begin
      dataReg   <= '0;
      scanEn    <= 1'b0;
      prescaler <= '0;
      idx       <= 2'd0;
      digi      <= DIGI_OFF;
    end else begin
      if (mem_wr && hitData) dataReg <= wdata;
      if (mem_wr && hitCtrl) scanEn  <= wdata[SCAN_EN_BIT];

      if (startScan) begin
        prescaler <= '0;
        idx       <= 2'd0;
      end else if (scanEn) begin
        if (prescaler == PRESC_LAST) begin
          prescaler <= '0;
          idx       <= idx + 2'd1;
        end else begin
          prescaler <= prescaler + DIV_W'(1);
        end
      end

      digi <= scanEn ? {anode, curSeg} : DIGI_OFF;
    end
  end

endmodule

// File: tb/tb_mmio_display_responder.sv
// Scoreboard-driven directed testbench for mmio_display_responder with SCAN_DIV=4.
// Decode-mode checks follow MMIO_DISPLAY_SEG_DECODE_EN; the default build checks raw mode.
module tb_mmio_display_responder;

  localparam logic [31:0] DATA_A   = 32'h4000_0010;
  localparam logic [31:0] CTRL_A   = 32'h4000_0014;
  localparam logic [31:0] STATUS_A = 32'h4000_0018;
  localparam logic [31:0] MISS_A   = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] rdata;
  logic        hit;
  logic [11:0] digi;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expT;

  expT sbQ[$];
  int  nAssert = 0;
  int  nFail   = 0;

  mmio_display_responder #(
    .BASE_ADDR (32'h4000_0010),
    .SCAN_DIV  (4),
    .DIV_W     (17)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .mem_wr (mem_wr),
    .mem_rd (mem_rd),
    .rdata  (rdata),
    .hit    (hit),
    .digi   (digi)
  );

  always #5 clk = ~clk;

  function automatic void pushExp(input string tag, input logic [31:0] value);
    expT e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endfunction

  task automatic checkOutput(input logic [31:0] observed);
    expT e;
    nAssert++;
    if (sbQ.size() == 0) begin
      nFail++;
      $error("[TB] FAIL scoreboard-empty observed=%h", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.value) else begin
        nFail++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [31:0] a, input logic [31:0] wd);
    mem_wr = wr;
    mem_rd = rd;
    addr   = a;
    wdata  = wd;
    #1;
  endtask

  // One bus cycle: drive at a negedge, check combinational outputs, then cross one posedge
  task automatic busAccess(input string tag, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic expHit, input logic [31:0] expRdata);
    pushExp({tag, "-hit"}, {31'b0, expHit});
    pushExp({tag, "-rdata"}, expRdata);
    applyStimulus(wr, rd, a, wd);
    checkOutput({31'b0, hit});
    checkOutput(rdata);
    @(negedge clk);
    mem_wr = 1'b0;
    mem_rd = 1'b0;
  endtask

  task automatic writeReg(input string tag, input logic [31:0] a, input logic [31:0] wd);
    busAccess(tag, 1'b1, 1'b0, a, wd, 1'b1, 32'h0);
  endtask

  task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] expVal);
    busAccess(tag, 1'b0, 1'b1, a, 32'h0, 1'b1, expVal);
  endtask

  task automatic checkDigi(input string tag, input logic [11:0] expVal);
    pushExp(tag, {20'b0, expVal});
    checkOutput({20'b0, digi});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    addr   = '0;
    wdata  = '0;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset values");
    checkDigi("rst-digi", 12'hFFF);
    readReg("rst-data", DATA_A, 32'h0);
    readReg("rst-ctrl", CTRL_A, 32'h0);
    readReg("rst-status", STATUS_A, 32'h0);

    $display("[TB] decode miss and read gating");
    busAccess("miss-wr", 1'b1, 1'b0, MISS_A, 32'hDEAD_BEEF, 1'b0, 32'h0);
    busAccess("miss-rd", 1'b0, 1'b1, MISS_A, 32'h0, 1'b0, 32'h0);
    readReg("miss-data-kept", DATA_A, 32'h0);
    busAccess("rd-gated", 1'b0, 1'b0, DATA_A, 32'h0, 1'b1, 32'h0);

    $display("[TB] simultaneous write and read, CTRL masking");
    writeReg("data5", DATA_A, 32'h5);
    busAccess("rmw", 1'b1, 1'b1, DATA_A, 32'h7, 1'b1, 32'h5);
    readReg("rmw-after", DATA_A, 32'h7);
    writeReg("ctrl-upper", CTRL_A, 32'hFFFF_FFFE);
    readReg("ctrl-masked", CTRL_A, 32'h0);

`ifdef MMIO_DISPLAY_SEG_DECODE_EN
    $display("[TB] decode mode scan");
    writeReg("dec-data", DATA_A, 32'h0000_1234);
    writeReg("dec-ctrl", CTRL_A, 32'h1);
    waitCycles(1);
    checkDigi("dec-T1", 12'hE99);
    waitCycles(4);
    checkDigi("dec-T5", 12'hDB0);
    waitCycles(12);
    checkDigi("dec-T17", 12'hE99);
    writeReg("dec-blank", DATA_A, 32'h0001_1234);
    waitCycles(1);
    checkDigi("dec-blanked", 12'hEFF);
`else
    $display("[TB] raw mode scan");
    writeReg("raw-data", DATA_A, 32'h8E99_F9C0);
    writeReg("raw-ctrl", CTRL_A, 32'h1);
    checkDigi("raw-T0", 12'hFFF);
    waitCycles(1);
    checkDigi("raw-T1", 12'hEC0);
    waitCycles(4);
    checkDigi("raw-T5", 12'hDF9);
    waitCycles(4);
    checkDigi("raw-T9", 12'hB99);
    waitCycles(4);
    checkDigi("raw-T13", 12'h78E);
    waitCycles(4);
    checkDigi("raw-T17", 12'hEC0);
`endif

    $display("[TB] restart, no-restart rewrite, pause and re-enable");
    writeReg("pause0", CTRL_A, 32'h0);
    writeReg("start", CTRL_A, 32'h1);
    waitCycles(5);
    writeReg("rewrite1", CTRL_A, 32'h1);
    readReg("no-restart-status", STATUS_A, 32'h1);
    writeReg("pause", CTRL_A, 32'h0);
    waitCycles(1);
    checkDigi("pause-digi", 12'hFFF);
    readReg("pause-status", STATUS_A, 32'h2);
    waitCycles(10);
    readReg("pause-hold-status", STATUS_A, 32'h2);
    checkDigi("pause-hold-digi", 12'hFFF);
    writeReg("reenable", CTRL_A, 32'h1);
    readReg("reenable-status", STATUS_A, 32'h0);
    pushExp("reenable-anode", 32'hE);
    checkOutput({28'b0, digi[11:8]});

    $display("[TB] reset mid-scan");
    waitCycles(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkDigi("rst2-digi", 12'hFFF);
    readReg("rst2-data", DATA_A, 32'h0);
    readReg("rst2-ctrl", CTRL_A, 32'h0);
    readReg("rst2-status", STATUS_A, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
